nonidem_region_unit: RTL

Runtime-programmable non-idempotent (I/O) region checker. Replaces the static compile-time region tables with NR_RULES writable base/length/control rule registers. NR_PORTS independent lookup channels, each with valid/ready handshake and a registered response. Consumed by the load unit and store buffer to block speculative and non-idempotent accesses.

---
 rtl/nonidem_region_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/nonidem_region_unit.sv
// Runtime-programmable non-idempotent region checker with NR_PORTS registered lookup channels.
// Optional per-port saturating hit counters are built when NONIDEM_REGION_STATS_EN is defined.
module nonidem_region_unit #(
  parameter int unsigned  NR_RULES   = 16,
  parameter int unsigned  ADDR_WIDTH = 64,
  parameter int unsigned  NR_PORTS   = 2,
  localparam int unsigned IDX_W      = (NR_RULES > 1) ? $clog2(NR_RULES) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cfg_we_i,
  input  logic [IDX_W-1:0]               cfg_idx_i,
  input  logic [1:0]                     cfg_sel_i,
  input  logic [ADDR_WIDTH-1:0]          cfg_wdata_i,
  output logic                           cfg_err_o,
  input  logic [NR_PORTS-1:0]            req_valid_i,
  output logic [NR_PORTS-1:0]            req_ready_o,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NR_PORTS-1:0]            resp_valid_o,
  input  logic [NR_PORTS-1:0]            resp_ready_i,
  output logic [NR_PORTS-1:0]            resp_nonidem_o,
  output logic [NR_PORTS*IDX_W-1:0]      resp_idx_o
`ifdef NONIDEM_REGION_STATS_EN
  ,
  input  logic                           hit_cnt_clr_i,
  output logic [NR_PORTS*32-1:0]         hit_cnt_o
`endif
);

  typedef enum logic [1:0] {
    SEL_BASE = 2'b00,
    SEL_LEN  = 2'b01,
    SEL_CTRL = 2'b10,
    SEL_RSVD = 2'b11
  } cfg_sel_e;

  logic [ADDR_WIDTH-1:0] r_base [NR_RULES];
  logic [ADDR_WIDTH-1:0] r_len  [NR_RULES];
  logic [NR_RULES-1:0]   r_en;
  logic [NR_RULES-1:0]   r_lock;
  logic                  r_cfg_err;

  cfg_sel_e w_sel;
  logic     w_idx_ok;
  logic     w_cfg_ok;

  assign w_sel    = cfg_sel_e'(cfg_sel_i);
  assign w_idx_ok = {1'b0, cfg_idx_i} < (IDX_W+1)'(NR_RULES);
  assign w_cfg_ok = cfg_we_i && w_idx_ok && (w_sel != SEL_RSVD) && !r_lock[cfg_idx_i];

  // NOTE: the rule table is reset register-by-register because every region must be
  // disabled the instant rst_ni falls; a reset-less memory could not guarantee that.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NR_RULES; k++) begin
        r_base[k] <= '0;
        r_len[k]  <= '0;
      end
      r_en      <= '0;
      r_lock    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we_i && !w_cfg_ok;
      if (w_cfg_ok) begin
        unique case (w_sel)
          SEL_BASE: r_base[cfg_idx_i] <= cfg_wdata_i;
          SEL_LEN:  r_len[cfg_idx_i]  <= cfg_wdata_i;
          SEL_CTRL: begin
            r_en[cfg_idx_i]   <= cfg_wdata_i[0];
            r_lock[cfg_idx_i] <= cfg_wdata_i[1];
          end
          default: ;
        endcase
      end
    end
  end

  assign cfg_err_o = r_cfg_err;

  // Evaluated one bit wider so a region ending exactly at 2^ADDR_WIDTH does not wrap.
  function automatic logic rule_match(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [ADDR_WIDTH-1:0] base,
                                      input logic [ADDR_WIDTH-1:0] len,
                                      input logic                  en);
    logic [ADDR_WIDTH:0] limit;
    limit = {1'b0, base} + {1'b0, len};
    return en && (addr >= base) && ({1'b0, addr} < limit);
  endfunction

  logic [NR_PORTS-1:0] w_hit;
  logic [IDX_W-1:0]    w_hit_idx [NR_PORTS];
  logic [NR_PORTS-1:0] w_accept;

  // NOTE: every combinational output is given a default before the loops so no latch is inferred.
  always_comb begin
    for (int p = 0; p < NR_PORTS; p++) begin
      w_hit[p]     = 1'b0;
      w_hit_idx[p] = '0;
      for (int k = 0; k < NR_RULES; k++) begin
        if (!w_hit[p] && rule_match(req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH],
                                    r_base[k], r_len[k], r_en[k])) begin
          w_hit[p]     = 1'b1;
          w_hit_idx[p] = IDX_W'(k);
        end
      end
    end
  end

  logic [NR_PORTS-1:0] r_resp_valid;
  logic [NR_PORTS-1:0] r_resp_nonidem;
  logic [IDX_W-1:0]    r_resp_idx [NR_PORTS];

  assign req_ready_o = ~r_resp_valid | resp_ready_i;
  assign w_accept    = req_valid_i & req_ready_o;

  // NOTE: state registers use non-blocking assignments so every port samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_resp_valid   <= '0;
      r_resp_nonidem <= '0;
      for (int p = 0; p < NR_PORTS; p++) r_resp_idx[p] <= '0;
    end else begin
      for (int p = 0; p < NR_PORTS; p++) begin
        if (w_accept[p]) begin
          r_resp_valid[p]   <= 1'b1;
          r_resp_nonidem[p] <= w_hit[p];
          r_resp_idx[p]     <= w_hit_idx[p];
        end else if (resp_ready_i[p]) begin
          r_resp_valid[p] <= 1'b0;
        end
      end
    end
  end

  assign resp_valid_o   = r_resp_valid;
  assign resp_nonidem_o = r_resp_nonidem;

  for (genvar gp = 0; gp < NR_PORTS; gp++) begin : g_port_out
    assign resp_idx_o[gp*IDX_W +: IDX_W] = r_resp_idx[gp];
  end

`ifdef NONIDEM_REGION_STATS_EN
  logic [31:0] r_hit_cnt [NR_PORTS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NR_PORTS; p++) r_hit_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NR_PORTS; p++) begin
        if (hit_cnt_clr_i) begin
          r_hit_cnt[p] <= '0;
        end else if (w_accept[p] && w_hit[p] && (r_hit_cnt[p] != 32'hFFFF_FFFF)) begin
          r_hit_cnt[p] <= r_hit_cnt[p] + 32'd1;
        end
      end
    end
  end

  for (genvar gp = 0; gp < NR_PORTS; gp++) begin : g_cnt_out
    assign hit_cnt_o[gp*32 +: 32] = r_hit_cnt[gp];
  end
`endif

endmodule
